// File: rtl/clk_freq_monitor_if.sv
// Signal bundle between a frequency monitor and its consumer: monitored clock,
// enable/clear controls and the per-window measurement results.
interface clk_freq_monitor_if #(
  parameter int WINDOW = 1024
);
  localparam int CNT_W = $clog2(WINDOW + 1);

  logic             mon_clk_in;
  logic             mon_en;
  logic             fault_clr;
  logic [CNT_W-1:0] edge_cnt;
  logic             meas_valid;
  logic             freq_ok;
  logic             fault;
  logic             rst_req;

  modport master (
    output mon_clk_in, mon_en, fault_clr,
    input  edge_cnt, meas_valid, freq_ok, fault, rst_req
  );

  modport slave (
    input  mon_clk_in, mon_en, fault_clr,
    output edge_cnt, meas_valid, freq_ok, fault, rst_req
  );
endinterface

// File: rtl/clk_freq_monitor.sv
// Counts rising edges of an asynchronous clock over a fixed clk_100m window and
// raises a sticky fault after FAIL_LIMIT bad windows. Optional: CLK_MON_STUCK_DET_EN.
module clk_freq_monitor #(
  parameter int WINDOW     = 1024,
  parameter int EXP_CNT    = 128,
  parameter int TOL        = 2,
  parameter int FAIL_LIMIT = 3,
  parameter int STUCK_CYC  = 64
) (
  input  logic               clk_100m,
  input  logic               rst_100m,
  clk_freq_monitor_if.slave  bus
);

  localparam int CNT_W  = $clog2(WINDOW + 1);
  localparam int WIN_W  = $clog2(WINDOW);
  localparam int FAIL_W = 4;

  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [FAIL_W-1:0]    FAIL_MAX = FAIL_W'(FAIL_LIMIT);
  localparam logic signed [31:0]   LO_LIM   = EXP_CNT - TOL;
  localparam logic signed [31:0]   HI_LIM   = EXP_CNT + TOL;

  if (WINDOW < 16) begin : g_chk_window
    $error("clk_freq_monitor: WINDOW must be at least 16");
  end
  if ((FAIL_LIMIT < 1) || (FAIL_LIMIT > 15)) begin : g_chk_fail
    $error("clk_freq_monitor: FAIL_LIMIT must be in 1..15");
  end
  if (STUCK_CYC < 1) begin : g_chk_stuck
    $error("clk_freq_monitor: STUCK_CYC must be positive");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_EVAL    = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [FAIL_W-1:0] sat_inc_fail(input logic [FAIL_W-1:0] f);
    return (f >= FAIL_MAX) ? FAIL_MAX : f + 1'b1;
  endfunction

  // Signed window check so a small EXP_CNT with a larger TOL cannot wrap.
  function automatic logic in_tol(input logic [CNT_W-1:0] c);
    logic signed [31:0] cs;
    cs = signed'(32'(c));
    return (cs >= LO_LIM) && (cs <= HI_LIM);
  endfunction

  state_e             state_q, state_d;
  logic               mon_p0_q, mon_p1_q, mon_p2_q;
  logic               edge_p2;
  logic [WIN_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   ecnt_q, ecnt_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               meas_valid_q, meas_valid_d;
  logic               freq_ok_q, freq_ok_d;
  logic               fault_q, fault_d;
  logic               rst_req_q;
  logic               win_bad;
  logic [FAIL_W-1:0]  fail_inc;

  // Stage p0/p1: two-flop synchronizer; p2: delay flop for edge detection
  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      mon_p0_q <= 1'b0;
      mon_p1_q <= 1'b0;
      mon_p2_q <= 1'b0;
    end else begin
      mon_p0_q <= bus.mon_clk_in;
      mon_p1_q <= mon_p0_q;
      mon_p2_q <= mon_p1_q;
    end
  end

  assign edge_p2  = mon_p1_q & ~mon_p2_q;
  assign win_bad  = ~in_tol(ecnt_q);
  assign fail_inc = sat_inc_fail(fail_q);

`ifdef CLK_MON_STUCK_DET_EN
  localparam int STK_W = $clog2(STUCK_CYC + 1);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_CYC);

  logic [STK_W-1:0] stuck_q, stuck_d;
  logic             stuck_hit;

  always_comb begin
    stuck_d = stuck_q;
    if (state_q == ST_IDLE) begin
      stuck_d = '0;
    end else if (edge_p2) begin
      stuck_d = '0;
    end else if (stuck_q != STK_MAX) begin
      stuck_d = stuck_q + 1'b1;
    end
  end

  assign stuck_hit = (state_q != ST_IDLE) && (stuck_q == STK_MAX);

  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      stuck_q <= '0;
    end else begin
      stuck_q <= stuck_d;
    end
  end
`else
  logic stuck_hit;
  assign stuck_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    ecnt_d       = ecnt_q;
    fail_d       = fail_q;
    edge_cnt_d   = edge_cnt_q;
    meas_valid_d = 1'b0;
    freq_ok_d    = freq_ok_q;
    fault_d      = fault_q;

    if (bus.fault_clr) begin
      fault_d = 1'b0;
      fail_d  = '0;
    end

    case (state_q)
      ST_IDLE: begin
        wcnt_d = '0;
        ecnt_d = '0;
        fail_d = '0;
        if (bus.mon_en) begin
          state_d = ST_MEASURE;
        end
      end

      ST_MEASURE: begin
        if (!bus.mon_en) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
          ecnt_d  = '0;
        end else begin
          if (edge_p2) begin
            ecnt_d = sat_inc_cnt(ecnt_q);
          end
          if (wcnt_q == WIN_LAST) begin
            state_d = ST_EVAL;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      ST_EVAL: begin
        wcnt_d = '0;
        ecnt_d = '0;
        if (!bus.mon_en) begin
          state_d = ST_IDLE;
        end else begin
          // Evaluation here overrides fault_clr so a simultaneous set wins.
          state_d      = ST_MEASURE;
          edge_cnt_d   = ecnt_q;
          meas_valid_d = 1'b1;
          freq_ok_d    = ~win_bad;
          if (win_bad) begin
            fail_d = fail_inc;
            if (fail_inc == FAIL_MAX) begin
              fault_d = 1'b1;
            end
          end else begin
            fail_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        wcnt_d  = '0;
        ecnt_d  = '0;
      end
    endcase

    if (stuck_hit) begin
      fault_d   = 1'b1;
      freq_ok_d = 1'b0;
    end
  end

  // Control and result registers; rst_req trails fault by one cycle
  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      ecnt_q       <= '0;
      fail_q       <= '0;
      edge_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
      freq_ok_q    <= 1'b0;
      fault_q      <= 1'b0;
      rst_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      ecnt_q       <= ecnt_d;
      fail_q       <= fail_d;
      edge_cnt_q   <= edge_cnt_d;
      meas_valid_q <= meas_valid_d;
      freq_ok_q    <= freq_ok_d;
      fault_q      <= fault_d;
      rst_req_q    <= fault_q;
    end
  end

  assign bus.edge_cnt   = edge_cnt_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.freq_ok    = freq_ok_q;
  assign bus.fault      = fault_q;
  assign bus.rst_req    = rst_req_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor: nominal, slow, recovery, enable/reset
// interruption and stuck-input scenarios at default parameters.
`timescale 1ns/1ps
module tb_clk_freq_monitor;
  localparam int W = 1024;

  logic    clk_100m = 1'b0;
  logic    rst_100m = 1'b1;
  int      n_chk = 0;
  int      n_fail = 0;
  realtime mon_half = 40.0;
  bit      mon_run = 1'b1;

  clk_freq_monitor_if #(.WINDOW(W)) bus ();

  clk_freq_monitor #(
    .WINDOW(W), .EXP_CNT(128), .TOL(2), .FAIL_LIMIT(3), .STUCK_CYC(64)
  ) dut (
    .clk_100m (clk_100m),
    .rst_100m (rst_100m),
    .bus      (bus)
  );

  always #5 clk_100m = ~clk_100m;

  initial bus.mon_clk_in = 1'b0;
  always begin
    if (mon_run) begin
      #(mon_half);
      bus.mon_clk_in = ~bus.mon_clk_in;
    end else begin
      bus.mon_clk_in = 1'b0;
      #1;
    end
  end

  task automatic do_reset();
    rst_100m      = 1'b1;
    bus.mon_en    = 1'b0;
    bus.fault_clr = 1'b0;
    repeat (3) @(posedge clk_100m);
    #1 rst_100m = 1'b0;
  endtask

  // Returns the number of posedges until meas_valid is seen (sampled #1 after).
  task automatic wait_valid(input string tag, output int cyc);
    for (cyc = 1; cyc <= 3000; cyc++) begin
      @(posedge clk_100m);
      #1;
      if (bus.meas_valid) return;
    end
    n_chk++; n_fail++;
    $display("FAIL %s: meas_valid timeout, got none in %0d cycles, required within 3000", tag, cyc);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (bus.edge_cnt !== '0) begin n_fail++; $display("FAIL reset_edge_cnt: got %0d want 0", bus.edge_cnt); end
    n_chk++; if (bus.meas_valid !== 1'b0) begin n_fail++; $display("FAIL reset_meas_valid: got %b want 0", bus.meas_valid); end
    n_chk++; if (bus.freq_ok !== 1'b0) begin n_fail++; $display("FAIL reset_freq_ok: got %b want 0", bus.freq_ok); end
    n_chk++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
    n_chk++; if (bus.rst_req !== 1'b0) begin n_fail++; $display("FAIL reset_rst_req: got %b want 0", bus.rst_req); end
  endtask

  task automatic test_nominal();
    int cyc;
    do_reset();
    mon_half = 40.0; mon_run = 1'b1;
    repeat (20) @(posedge clk_100m);
    #1 bus.mon_en = 1'b1;
    wait_valid("nom_first", cyc);
    n_chk++; if (cyc != W + 2) begin n_fail++; $display("FAIL nom_first_latency: got %0d want %0d", cyc, W + 2); end
    n_chk++; if (bus.edge_cnt < 127 || bus.edge_cnt > 129) begin n_fail++; $display("FAIL nom_edge_cnt: got %0d want 127..129", bus.edge_cnt); end
    n_chk++; if (bus.freq_ok !== 1'b1) begin n_fail++; $display("FAIL nom_freq_ok: got %b want 1", bus.freq_ok); end
    n_chk++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL nom_fault: got %b want 0", bus.fault); end
    @(posedge clk_100m); #1;
    n_chk++; if (bus.meas_valid !== 1'b0) begin n_fail++; $display("FAIL nom_pulse_width: got %b want 0", bus.meas_valid); end
    wait_valid("nom_second", cyc);
    n_chk++; if (cyc != W) begin n_fail++; $display("FAIL nom_period: got %0d want %0d", cyc + 1, W + 1); end
    n_chk++; if (bus.edge_cnt < 127 || bus.edge_cnt > 129) begin n_fail++; $display("FAIL nom_edge_cnt2: got %0d want 127..129", bus.edge_cnt); end
    n_chk++; if (bus.freq_ok !== 1'b1) begin n_fail++; $display("FAIL nom_freq_ok2: got %b want 1", bus.freq_ok); end
  endtask

  task automatic test_slow_clock();
    int cyc;
    do_reset();
    mon_half = 50.0; mon_run = 1'b1;
    repeat (20) @(posedge clk_100m);
    #1 bus.mon_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_valid("slow_win", cyc);
      n_chk++; if (bus.edge_cnt < 100 || bus.edge_cnt > 105) begin n_fail++; $display("FAIL slow_edge_cnt w%0d: got %0d want 100..105", k, bus.edge_cnt); end
      n_chk++; if (bus.freq_ok !== 1'b0) begin n_fail++; $display("FAIL slow_freq_ok w%0d: got %b want 0", k, bus.freq_ok); end
      n_chk++; if (bus.fault !== (k == 3)) begin n_fail++; $display("FAIL slow_fault w%0d: got %b want %b", k, bus.fault, (k == 3)); end
      n_chk++; if (bus.rst_req !== 1'b0) begin n_fail++; $display("FAIL slow_rst_req_early w%0d: got %b want 0", k, bus.rst_req); end
    end
    @(posedge clk_100m); #1;
    n_chk++; if (bus.rst_req !== 1'b1) begin n_fail++; $display("FAIL slow_rst_req: got %b want 1", bus.rst_req); end
    repeat (300) @(posedge clk_100m);
    #1 rst_100m = 1'b1;
    @(posedge clk_100m); #1;
    n_chk++; if (bus.edge_cnt !== '0 || bus.meas_valid !== 1'b0 || bus.freq_ok !== 1'b0 ||
                 bus.fault !== 1'b0 || bus.rst_req !== 1'b0) begin
      n_fail++;
      $display("FAIL midwin_reset: got cnt=%0d vld=%b ok=%b fault=%b req=%b want all 0",
               bus.edge_cnt, bus.meas_valid, bus.freq_ok, bus.fault, bus.rst_req);
    end
    rst_100m = 1'b0;
  endtask

  task automatic test_recovery();
    int cyc;
    do_reset();
    mon_half = 50.0; mon_run = 1'b1;
    repeat (20) @(posedge clk_100m);
    #1 bus.mon_en = 1'b1;
    wait_valid("rec_w1", cyc);
    wait_valid("rec_w2", cyc);
    n_chk++; if (bus.freq_ok !== 1'b0 || bus.fault !== 1'b0) begin n_fail++; $display("FAIL rec_w2: got ok=%b fault=%b want ok=0 fault=0", bus.freq_ok, bus.fault); end
    mon_half = 40.0;
    wait_valid("rec_w3", cyc);
    n_chk++; if (bus.freq_ok !== 1'b1 || bus.fault !== 1'b0) begin n_fail++; $display("FAIL rec_good: got ok=%b fault=%b cnt=%0d want ok=1 fault=0", bus.freq_ok, bus.fault, bus.edge_cnt); end
    mon_half = 50.0;
    wait_valid("rec_w4", cyc);
    n_chk++; if (bus.freq_ok !== 1'b0 || bus.fault !== 1'b0) begin n_fail++; $display("FAIL rec_fail_cleared: got ok=%b fault=%b want ok=0 fault=0", bus.freq_ok, bus.fault); end
    wait_valid("rec_w5", cyc);
    n_chk++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL rec_w5_fault: got %b want 0", bus.fault); end
    repeat (W) @(posedge clk_100m);
    #1 bus.fault_clr = 1'b1;
    @(posedge clk_100m); #1;
    bus.fault_clr = 1'b0;
    n_chk++; if (bus.meas_valid !== 1'b1 || bus.fault !== 1'b1) begin n_fail++; $display("FAIL rec_set_wins: got vld=%b fault=%b want vld=1 fault=1", bus.meas_valid, bus.fault); end
    @(posedge clk_100m); #1;
    n_chk++; if (bus.rst_req !== 1'b1) begin n_fail++; $display("FAIL rec_rst_req: got %b want 1", bus.rst_req); end
    bus.fault_clr = 1'b1;
    @(posedge clk_100m); #1;
    bus.fault_clr = 1'b0;
    n_chk++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL rec_fault_clr: got %b want 0", bus.fault); end
    @(posedge clk_100m); #1;
    n_chk++; if (bus.rst_req !== 1'b0) begin n_fail++; $display("FAIL rec_rst_req_clr: got %b want 0", bus.rst_req); end
  endtask

  task automatic test_enable_drop();
    int cyc;
    int pulses;
    logic [$clog2(W+1)-1:0] prev;
    do_reset();
    mon_half = 40.0; mon_run = 1'b1;
    repeat (20) @(posedge clk_100m);
    #1 bus.mon_en = 1'b1;
    wait_valid("en_w1", cyc);
    prev = bus.edge_cnt;
    repeat (500) @(posedge clk_100m);
    #1 bus.mon_en = 1'b0;
    pulses = 0;
    for (int i = 0; i < W + 20; i++) begin
      @(posedge clk_100m); #1;
      if (bus.meas_valid) pulses++;
    end
    n_chk++; if (pulses != 0) begin n_fail++; $display("FAIL en_no_valid: got %0d pulses want 0", pulses); end
    n_chk++; if (bus.edge_cnt !== prev) begin n_fail++; $display("FAIL en_edge_hold: got %0d want %0d", bus.edge_cnt, prev); end
    bus.mon_en = 1'b1;
    wait_valid("en_restart", cyc);
    n_chk++; if (cyc != W + 2) begin n_fail++; $display("FAIL en_restart_latency: got %0d want %0d", cyc, W + 2); end
  endtask

  task automatic test_stuck();
    int cyc;
    do_reset();
`ifdef CLK_MON_STUCK_DET_EN
    mon_half = 40.0; mon_run = 1'b1;
    repeat (20) @(posedge clk_100m);
    #1 bus.mon_en = 1'b1;
    wait_valid("stuck_pre", cyc);
    repeat (200) @(posedge clk_100m);
    #1 mon_run = 1'b0;
    cyc = 0;
    while (!bus.fault && cyc < 500) begin
      @(posedge clk_100m); #1;
      cyc++;
    end
    n_chk++; if (cyc < 55 || cyc > 75) begin n_fail++; $display("FAIL stuck_fault_delay: got %0d cycles want 55..75", cyc); end
    n_chk++; if (bus.freq_ok !== 1'b0) begin n_fail++; $display("FAIL stuck_freq_ok: got %b want 0", bus.freq_ok); end
`else
    mon_run = 1'b0;
    repeat (20) @(posedge clk_100m);
    #1 bus.mon_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_valid("stuck_win", cyc);
      n_chk++; if (bus.edge_cnt !== '0) begin n_fail++; $display("FAIL stuck_edge_cnt w%0d: got %0d want 0", k, bus.edge_cnt); end
      n_chk++; if (bus.fault !== (k == 3)) begin n_fail++; $display("FAIL stuck_fault w%0d: got %b want %b", k, bus.fault, (k == 3)); end
    end
`endif
  endtask

  initial begin
    bus.mon_en    = 1'b0;
    bus.fault_clr = 1'b0;
    test_reset();
    test_nominal();
    test_slow_clock();
    test_recovery();
    test_enable_drop();
    test_stuck();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
